priority_scan_encoder: RTL

Sequential, parametrised priority encoder for the BISR weight-proxy repair path. It takes a snapshot of a fault/spare bitmap and streams out the index of every bit equal to `ENCODED_VAL`, one per accepted handshake, in LSB-first or MSB-first order. It counts the matches and flags completion. It sits between the BIST result register and the remap allocator, which consumes indices at its own pace.

---
 rtl/priority_scan_encoder.sv | 102 ++++++++++
 1 files changed

// File: rtl/priority_scan_encoder.sv
// priority_scan_encoder: streams the index of every bitmap bit equal to ENCODED_VAL; `PRIORITY_SCAN_ABORT_EN adds an abort input.
// Latency: first index one cycle after start; done pulses one cycle after the last accepted index.
// Backpressure: idx_out/idx_valid hold while idx_ready is low; one index retires per accepted handshake.
module priority_scan_encoder #(
  parameter int INPUT_WIDTH = 16,
  parameter int ENCODED_VAL = 0,
  parameter int MSB_FIRST   = 0,
  localparam int IDX_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1,
  localparam int CNT_W = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [INPUT_WIDTH-1:0] data_in,
`ifdef PRIORITY_SCAN_ABORT_EN
  input  logic                   abort,
`endif
  output logic [IDX_W-1:0]       idx_out,
  output logic                   idx_valid,
  input  logic                   idx_ready,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       match_count,
  output logic                   none_found
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state;
  logic [INPUT_WIDTH-1:0] mask;
  logic [INPUT_WIDTH-1:0] load_mask;
  logic [INPUT_WIDTH-1:0] clr_bit;
  logic [INPUT_WIDTH-1:0] mask_nxt;
  logic [IDX_W-1:0]       enc_idx;
  logic [CNT_W-1:0]       count_nxt;
  logic                   accept;
  logic                   abort_req;
  logic                   scan_end;

  // Last write in the loop wins, so loop direction selects the priority end.
  always_comb begin
    enc_idx = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < INPUT_WIDTH; i++)
        if (mask[i]) enc_idx = IDX_W'(i);
    end else begin
      for (int i = INPUT_WIDTH - 1; i >= 0; i--)
        if (mask[i]) enc_idx = IDX_W'(i);
    end
  end

`ifdef PRIORITY_SCAN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign load_mask = (ENCODED_VAL != 0) ? data_in : ~data_in;
  assign idx_valid = (state == S_SCAN) && (|mask);
  assign idx_out   = idx_valid ? enc_idx : '0;
  assign accept    = idx_valid & idx_ready;
  assign clr_bit   = accept ? (INPUT_WIDTH'(1) << enc_idx) : '0;
  assign mask_nxt  = mask & ~clr_bit;
  assign count_nxt = match_count + CNT_W'(accept);
  // Leave SCAN on the edge that retires the last index so done lands one cycle later.
  assign scan_end  = (mask_nxt == '0) | abort_req;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mask        <= '0;
      match_count <= '0;
      none_found  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_SCAN;
            mask        <= load_mask;
            match_count <= '0;
            none_found  <= 1'b0;
          end
        end
        S_SCAN: begin
          mask        <= abort_req ? '0 : mask_nxt;
          match_count <= count_nxt;
          if (scan_end) begin
            state      <= S_DONE;
            none_found <= (count_nxt == '0);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
